// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, load/store and memory-bus signals shared by the arbiter and its neighbours
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        if_stall;
  logic        mem_req;
  logic        mem_we;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_done;
  logic        mem_err;
  logic        mem_stall;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic        bus_ready;
  logic [31:0] bus_rdata;
  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_funct3, mem_addr, mem_wdata, bus_ready, bus_rdata,
    output if_rdata, if_done, if_stall, mem_rdata, mem_done, mem_err, mem_stall,
           bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata
  );
  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_funct3, mem_addr, mem_wdata, bus_ready, bus_rdata,
    input  if_rdata, if_done, if_stall, mem_rdata, mem_done, mem_err, mem_stall,
           bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory bus between instruction fetch and load/store, with starvation guard
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input logic           clk,
  input logic           reset,
  mem_port_arbiter_if.slave p
);
  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_MEM, RESP} state_t;
  state_t      r_state, w_next;
  logic [3:0]  r_cnt;
  logic        r_gnt_mem, r_err, r_we;
  logic [1:0]  r_off;
  logic [31:0] r_addr, r_wdata, r_rdata;
  logic [3:0]  r_strb;
  logic [1:0]  w_size, w_off;
  logic        w_mis, w_gnt_mem, w_gnt_if, w_store, w_bus_req, w_if_done, w_mem_done, w_unused;
  logic [3:0]  w_strb;
  logic [31:0] w_wdata;
  assign w_size    = p.mem_funct3[1:0];
  assign w_off     = p.mem_addr[1:0];
  assign w_mis     = (w_size == 2'd3) | (w_size == 2'd1 & w_off[0]) | (w_size == 2'd2 & |w_off);
  assign w_gnt_mem = p.mem_req & ~(p.if_req & r_cnt == 4'(STARVE_LIMIT));
  assign w_gnt_if  = p.if_req & ~w_gnt_mem;
  assign w_store   = w_gnt_mem & p.mem_we & ~w_mis;
  assign w_strb    = w_size == 2'd0 ? 4'b0001 << w_off : w_size == 2'd1 ? (w_off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign w_wdata   = w_size == 2'd0 ? {4{p.mem_wdata[7:0]}} : w_size == 2'd1 ? {2{p.mem_wdata[15:0]}} : p.mem_wdata;
  assign w_unused  = &{1'b0, p.mem_funct3[2], p.if_addr[1:0]};
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:              w_next = w_gnt_mem ? (w_mis ? RESP : BUSY_MEM) : w_gnt_if ? BUSY_IF : IDLE;
      BUSY_IF, BUSY_MEM: w_next = p.bus_ready ? RESP : r_state;
      default:           w_next = IDLE;
    endcase
  end
  always_comb begin
    w_bus_req  = r_state == BUSY_IF || r_state == BUSY_MEM;
    w_if_done  = r_state == RESP && !r_gnt_mem;
    w_mem_done = r_state == RESP && r_gnt_mem;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt     <= '0;
      r_gnt_mem <= 1'b0;
      r_err     <= 1'b0;
      r_we      <= 1'b0;
      r_off     <= '0;
      r_addr    <= '0;
      r_strb    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
    end else begin
      if (r_state == IDLE && (w_gnt_mem || w_gnt_if)) begin
        r_gnt_mem <= w_gnt_mem;
        r_err     <= w_gnt_mem & w_mis;
        r_we      <= w_store;
        r_off     <= w_gnt_mem ? w_off : 2'd0;
        r_addr    <= {w_gnt_mem ? p.mem_addr[31:2] : p.if_addr[31:2], 2'b00};
        r_strb    <= w_store ? w_strb : 4'd0;
        r_wdata   <= w_store ? w_wdata : 32'd0;
        r_rdata   <= '0;
        // a MEM grant can only happen below the limit while IF waits, so +1 never overshoots
        r_cnt     <= (w_gnt_mem & p.if_req) ? r_cnt + 4'd1 : 4'd0;
      end
      if (w_bus_req && p.bus_ready) r_rdata <= p.bus_rdata;
    end
  end
  assign p.bus_req   = w_bus_req;
  assign p.bus_we    = r_we;
  assign p.bus_addr  = r_addr;
  assign p.bus_wstrb = r_strb;
  assign p.bus_wdata = r_wdata;
  assign p.if_done   = w_if_done;
  assign p.if_rdata  = w_if_done ? r_rdata : 32'd0;
  assign p.mem_done  = w_mem_done;
  assign p.mem_err   = w_mem_done & r_err;
  assign p.mem_rdata = (w_mem_done & ~r_we & ~r_err) ? r_rdata >> {r_off, 3'b000} : 32'd0;
  assign p.if_stall  = reset & p.if_req & ~w_if_done;
  assign p.mem_stall = reset & p.mem_req & ~w_mem_done;
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported memory bus between instruction fetch (IF) and the MEM-stage load/store path of the 5-stage RISC-V core.
- Arbitrates the two requesters and sequences each bus transaction with a ready handshake.
- Produces byte strobes and replicated write data for stores, and right-justified load data; sign/zero extension happens downstream in the WB path.
- Raises per-requester stalls to the pipeline registers.

Parameters:
- STARVE_LIMIT, 4: maximum consecutive MEM grants while if_req is pending before IF is forced priority; legal range 1-15.

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-low
- if_req  in  1  fetch request; held until if_done
- if_addr  in  32  fetch address; bits [1:0] ignored
- if_rdata  out  32  fetched word; valid while if_done=1
- if_done  out  1  one-cycle completion pulse
- if_stall  out  1  if_req & ~if_done
- mem_req  in  1  load/store request; held until mem_done
- mem_we  in  1  1 = store
- mem_funct3  in  3  access size in [1:0]: 00 byte, 01 half, 10 word, 11 illegal
- mem_addr  in  32  byte address
- mem_wdata  in  32  store data, right-justified
- mem_rdata  out  32  load data, shifted right by 8*addr[1:0], not extended; 0 for stores and errors
- mem_done  out  1  one-cycle completion pulse
- mem_err  out  1  pulses with mem_done on a misaligned or illegal access
- mem_stall  out  1  mem_req & ~mem_done
- bus_req  out  1  bus transaction valid
- bus_we  out  1  bus write
- bus_addr  out  32  word address, bits [1:0] = 0
- bus_wstrb  out  4  byte strobes; 0000 on reads
- bus_wdata  out  32  write data
- bus_ready  in  1  bus accepts/completes the current beat
- bus_rdata  in  32  read data, valid with bus_ready

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- While reset=0: state IDLE, starvation counter 0; every output is 0, including bus_req.
- FSM states: IDLE, BUSY_IF, BUSY_MEM, RESP.
- IDLE, no request: stay in IDLE; bus_req=0.
- IDLE grant rule: grant MEM if mem_req and not (if_req and starve_cnt==STARVE_LIMIT); otherwise grant IF if if_req.
- IDLE, MEM granted and access misaligned or illegal: no bus transaction; go to RESP with mem_err=1.
- IDLE, normal grant: register bus_addr, bus_we, bus_wstrb and bus_wdata, then go to BUSY_IF or BUSY_MEM.
- Starvation counter:
  - MEM grant with if_req=1: increment, saturating at STARVE_LIMIT.
  - IF grant, or MEM grant with if_req=0: clear.
- BUSY_x: bus_req=1; all bus_* outputs held stable.
  - bus_ready=0: stay.
  - bus_ready=1: capture bus_rdata (loads/fetch) and go to RESP.
- RESP: exactly one done pulse for the granted requester, with its rdata valid; bus_req=0; next state IDLE.
- Latency: request seen in IDLE at cycle 0 -> bus_req at cycle 1 -> done at cycle N+2, where N = number of bus_ready=0 cycles. Minimum latency is 2; minimum issue interval is 3 cycles.
- A request whose requester drops it before done still completes on the bus. The done pulse is produced but ignored.
- Alignment:
  - Byte: any offset.
  - Half: offset 0 or 2.
  - Word: offset 0.
  - Any other offset, or size 11: misaligned.
- Store strobes and data:
  - SB: wstrb = 0001 << off; wdata = wdata[7:0] replicated x4.
  - SH: wstrb 0011 at offset 0, 1100 at offset 2; wdata = wdata[15:0] replicated x2.
  - SW: wstrb 1111; wdata unchanged.
- Loads: bus_we=0, wstrb=0000.
  - mem_rdata = bus_rdata >> (8*off).
  - Upper bits beyond the access size: the shifted-in zeros / remaining bytes are passed through.
- Fetch: always a read of {if_addr[31:2], 2'b00}; if_rdata = bus_rdata.
- Simultaneous requests are resolved only in IDLE. No requester is preempted mid-transaction.
- Reset mid-transaction: bus_req drops immediately (asynchronously) and no done pulse is issued. The bus slave must tolerate an abandoned beat.

Test Plan:
- Fetch, if_addr=0x104, bus_ready=1 first BUSY cycle, bus_rdata=0x00000013 -> bus_addr=0x104, bus_we=0 at cycle 1; if_done=1 and if_rdata=0x13 at cycle 2; if_stall=1 at cycles 0-1.
- LB, mem_addr=0x203, bus_rdata=0xAABBCCDD, bus_ready delayed 3 cycles -> bus_addr=0x200, wstrb=0000, mem_done at cycle 5, mem_rdata=0x000000AA.
- SH, mem_addr=0x302, mem_wdata=0x1234ABCD -> bus_we=1, wstrb=1100, bus_wdata=0xABCDABCD, bus_addr=0x300; mem_rdata=0.
- SW at 0x401, then funct3=3'b011 at 0x400 -> each gives mem_done=1, mem_err=1 two... one cycle after grant; bus_req never asserted.
- STARVE_LIMIT=4, if_req and mem_req held high, requests re-issued on each done, bus_ready=1 -> grant order M,M,M,M,I,M,M,M,M,I.
- Reset driven low during BUSY_MEM with bus_ready=0 -> bus_req=0 in the same cycle, all outputs 0; after release, no done pulse, and a fresh request completes normally.
